pdm_out_stage: RTL and testbench

PDM_OUT_STAGE -- requirements
Module: pdm_out_stage

---
 rtl/synth_pkg.sv | 14 +
 rtl/dac_modulator.sv | 37 +++
 rtl/pdm_out_stage.sv | 106 ++++++++++
 tb/tb_pdm_out_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth output path.
// Holds the output sample width, midscale level and DAC mode encoding.
package synth_pkg;

  localparam int OUT_BITS = 8;

  localparam logic [OUT_BITS-1:0] MIDSCALE = 8'h80;

  typedef enum logic {
    PWM = 1'b0,
    SD  = 1'b1
  } dac_mode_e;

endpackage

// File: rtl/dac_modulator.sv
// 1-bit DAC modulator: PWM comparator and first-order sigma-delta.
// Ports: clk, rst_n, cnt (frame counter), level, mode (0 PWM / 1 SD), dac_out.
module dac_modulator
  import synth_pkg::*;
#(
  parameter int BITS = OUT_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] cnt,
  input  logic [BITS-1:0] level,
  input  logic            mode,
  output logic            dac_out
);

  logic [BITS-1:0] acc;
  logic [BITS:0]   sum;
  logic            pwm_bit;
  logic            sd_bit;

  assign sum     = {1'b0, acc} + {1'b0, level};
  assign sd_bit  = sum[BITS];
  assign pwm_bit = cnt < level;

  // The accumulator runs in both modes so a mode switch
  // continues from wherever the error term happens to be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else begin
      acc     <= sum[BITS-1:0];
      dac_out <= (mode == SD) ? sd_bit : pwm_bit;
    end
  end

endmodule

// File: rtl/pdm_out_stage.sv
// Output stage: frame-aligned sample holding, soft mute and overrun flag.
// Ports: clk, rst_n, sample_in/valid/ready, mode, mute, clear_overrun,
//        dac_out, frame_start, overrun.
module pdm_out_stage
  import synth_pkg::*;
#(
  parameter int SAMPLE_BITS = OUT_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  input  logic                   sample_valid,
  output logic                   sample_ready,
  input  logic                   mode,
  input  logic                   mute,
  input  logic                   clear_overrun,
  output logic                   dac_out,
  output logic                   frame_start,
  output logic                   overrun
);

  localparam logic [SAMPLE_BITS-1:0] MID =
    {1'b1, {(SAMPLE_BITS-1){1'b0}}};
  localparam logic [SAMPLE_BITS-1:0] ONE =
    SAMPLE_BITS'(1);

  logic [SAMPLE_BITS-1:0] frame_cnt;
  logic [SAMPLE_BITS-1:0] hold;
  logic                   hold_valid;
  logic [SAMPLE_BITS-1:0] level;
  dac_mode_e              mode_q;

  logic [SAMPLE_BITS-1:0] level_nxt;
  logic                   hold_valid_nxt;
  dac_mode_e              mode_nxt;
  logic                   accept;
  logic                   drop;

  assign frame_start  = (frame_cnt == '0);
  assign sample_ready = !hold_valid | frame_start;
  assign accept       = sample_valid & sample_ready;
  assign drop         = sample_valid & !sample_ready;

  always_comb begin
    level_nxt = level;
    if (frame_start) begin
      if (mute) begin
        if (level > MID) begin
          level_nxt = level - ONE;
        end else if (level < MID) begin
          level_nxt = level + ONE;
        end
      end else if (hold_valid) begin
        level_nxt = hold;
      end
    end
  end

  // A frame boundary always empties the holding slot (into level,
  // or discarded under mute); a same-cycle accept refills it.
  always_comb begin
    hold_valid_nxt = hold_valid;
    if (frame_start) begin
      hold_valid_nxt = 1'b0;
    end
    if (accept) begin
      hold_valid_nxt = 1'b1;
    end
  end

  assign mode_nxt = frame_start ? dac_mode_e'(mode) : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt  <= '0;
      hold       <= MID;
      hold_valid <= 1'b0;
      level      <= MID;
      mode_q     <= PWM;
      overrun    <= 1'b0;
    end else begin
      frame_cnt  <= frame_cnt + ONE;
      hold_valid <= hold_valid_nxt;
      level      <= level_nxt;
      mode_q     <= mode_nxt;
      if (accept) begin
        hold <= sample_in;
      end
      overrun <= drop | (overrun & !clear_overrun);
    end
  end

  // The modulator sees the level/mode being loaded at frame start,
  // so the counter-zero slot already belongs to the new frame.
  dac_modulator #(
    .BITS (SAMPLE_BITS)
  ) u_mod (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt     (frame_cnt),
    .level   (level_nxt),
    .mode    (mode_nxt),
    .dac_out (dac_out)
  );

endmodule

// File: tb/tb_pdm_out_stage.sv
// Directed self-checking bench for pdm_out_stage.
// Measures whole frames of dac_out and compares against hand-derived patterns.
module tb_pdm_out_stage;

  logic       clk;
  logic       rst_n;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic       sample_ready;
  logic       mode;
  logic       mute;
  logic       clear_overrun;
  logic       dac_out;
  logic       frame_start;
  logic       overrun;

  int n_assert;
  int n_fail;

  logic [255:0] pat;

  pdm_out_stage #(.SAMPLE_BITS(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .mode          (mode),
    .mute          (mute),
    .clear_overrun (clear_overrun),
    .dac_out       (dac_out),
    .frame_start   (frame_start),
    .overrun       (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pwm_pat(input int l);
    logic [255:0] p;
    p = '0;
    for (int k = 0; k < 256; k++) p[k] = (k < l);
    return p;
  endfunction

  function automatic int ones(input logic [255:0] p);
    return $countones(p);
  endfunction

  task automatic wait_frame_start();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1;
        break;
      end
    end
    n_assert++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL wait_frame_start: observed timeout expected frame_start");
    end
  endtask

  // Offer one sample at the current negedge for a single cycle.
  task automatic offer(input logic [7:0] d, input logic exp_ready,
                       input string tag);
    sample_valid = 1'b1;
    sample_in    = d;
    #1;
    check(tag, {255'b0, sample_ready}, {255'b0, exp_ready});
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Called at the negedge of a frame_start cycle; records the 256
  // dac_out bits of that frame and returns at the next frame_start.
  task automatic measure_frame(input int toggle_at,
                               input logic toggle_val,
                               input logic offer_en,
                               input logic [7:0] offer_data,
                               output logic [255:0] p);
    p = '0;
    if (offer_en) begin
      sample_valid = 1'b1;
      sample_in    = offer_data;
      #1;
      check("ready_at_cnt0", {255'b0, sample_ready}, 256'd1);
    end
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      p[k] = dac_out;
      if (k == toggle_at) mode = toggle_val;
    end
    check("frame_start_after_measure", {255'b0, frame_start}, 256'd1);
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    sample_in     = 8'h00;
    sample_valid  = 1'b0;
    mode          = 1'b0;
    mute          = 1'b0;
    clear_overrun = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dac_out", {255'b0, dac_out}, 256'd0);
    check("rst_overrun", {255'b0, overrun}, 256'd0);
    rst_n = 1'b1;
    #1;
    check("rel_frame_start", {255'b0, frame_start}, 256'd1);
    check("rel_ready", {255'b0, sample_ready}, 256'd1);

    // Idle: midscale PWM, 128 ones
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("idle_pattern", pat, pwm_pat(128));
    check("idle_ready", {255'b0, sample_ready}, 256'd1);

    // PWM 0x40 accepted mid-frame
    repeat (10) @(negedge clk);
    offer(8'h40, 1'b1, "pwm40_ready");
    wait_frame_start();
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("pwm40_pattern", pat, pwm_pat(64));

    // Sigma-delta level 0x01 then 0xFF
    repeat (5) @(negedge clk);
    mode = 1'b1;
    offer(8'h01, 1'b1, "sd01_ready");
    wait_frame_start();
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("sd01_ones", 256'(ones(pat)), 256'd1);

    repeat (5) @(negedge clk);
    offer(8'hFF, 1'b1, "sdff_ready");
    wait_frame_start();
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("sdff_ones", 256'(ones(pat)), 256'd255);

    // SD 0x40 with a mid-frame switch to PWM
    repeat (5) @(negedge clk);
    offer(8'h40, 1'b1, "sd40_ready");
    wait_frame_start();
    measure_frame(100, 1'b0, 1'b0, 8'h00, pat);
    check("sd40_ones", 256'(ones(pat)), 256'd64);
    check("sd40_upper_half", 256'(ones({128'b0, pat[255:128]})), 256'd32);
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("pwm_after_toggle", pat, pwm_pat(64));

    // Overrun: second sample in the same frame is dropped
    repeat (5) @(negedge clk);
    offer(8'h10, 1'b1, "ovr_first_ready");
    offer(8'h20, 1'b0, "ovr_second_ready");
    check("ovr_set", {255'b0, overrun}, 256'd1);
    wait_frame_start();
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("ovr_level10", pat, pwm_pat(16));
    check("ovr_sticky", {255'b0, overrun}, 256'd1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("ovr_cleared", {255'b0, overrun}, 256'd0);

    // Set and clear in the same cycle: set wins
    repeat (5) @(negedge clk);
    offer(8'h30, 1'b1, "ovr2_first_ready");
    sample_valid  = 1'b1;
    sample_in     = 8'h31;
    clear_overrun = 1'b1;
    #1;
    check("ovr2_second_ready", {255'b0, sample_ready}, 256'd0);
    @(negedge clk);
    sample_valid  = 1'b0;
    clear_overrun = 1'b0;
    check("ovr2_set_wins", {255'b0, overrun}, 256'd1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("ovr2_cleared", {255'b0, overrun}, 256'd0);
    check("ovr2_hold_full", {255'b0, sample_ready}, 256'd0);

    // Offer at frame_cnt == 0 while holding 0x30
    wait_frame_start();
    measure_frame(-1, 1'b0, 1'b1, 8'h50, pat);
    check("cnt0_old_hold_level", pat, pwm_pat(48));
    check("cnt0_no_overrun", {255'b0, overrun}, 256'd0);
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("cnt0_new_level", pat, pwm_pat(80));

    // Soft mute from 0x85
    repeat (5) @(negedge clk);
    offer(8'h85, 1'b1, "mute85_ready");
    wait_frame_start();
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("mute_start_85", pat, pwm_pat(133));
    mute = 1'b1;
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("mute_84", pat, pwm_pat(132));
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("mute_83", pat, pwm_pat(131));
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("mute_82", pat, pwm_pat(130));
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("mute_81", pat, pwm_pat(129));
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("mute_80", pat, pwm_pat(128));

    // Held sample is discarded while muted
    repeat (5) @(negedge clk);
    offer(8'h20, 1'b1, "mute_offer_ready");
    wait_frame_start();
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("mute_hold_80", pat, pwm_pat(128));
    mute = 1'b0;
    measure_frame(-1, 1'b0, 1'b0, 8'h00, pat);
    check("unmute_80", pat, pwm_pat(128));
    @(negedge clk);
    check("unmute_ready", {255'b0, sample_ready}, 256'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
